// File: rtl/stripe_ctrl.sv
// -----------------------------------------------------------------------------
// stripe_ctrl
//   Lane scheduler for the two-lane byte-striping path. Accepted words go
//   strictly alternately to lane 0 and lane 1, and every burst starts on
//   lane 0. Upstream is stalled while the target lane's FIFO is almost full,
//   so the unstriping side can always rebuild the original word order.
//
// Ports
//   clk_2f          in   single clock, all logic on the rising edge
//   reset_L         in   synchronous active-low reset
//   data_in         in   WIDTH-bit input word
//   valid_in        in   input word present
//   ready_out       out  combinational; word accepted when valid_in && ready_out
//   almost_full_0/1 in   lane FIFO cannot take another word
//   selector        out  lane the next accepted word goes to
//   data_out0/1     out  registered lane words
//   valid_out_0/1   out  one-cycle pulse, matching data_outN is new
//   words_0/1       out  per-lane accepted-word counters, wrap on overflow
//   state           out  IDLE=00, STRIPE=01, STALL=10
//   proto_err       out  sticky: valid_in dropped while stalled
// -----------------------------------------------------------------------------
module stripe_ctrl #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_2f,
    input  logic                 reset_L,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 almost_full_0,
    input  logic                 almost_full_1,
    output logic                 selector,
    output logic [WIDTH-1:0]     data_out0,
    output logic [WIDTH-1:0]     data_out1,
    output logic                 valid_out_0,
    output logic                 valid_out_1,
    output logic [CNT_WIDTH-1:0] words_0,
    output logic [CNT_WIDTH-1:0] words_1,
    output logic [1:0]           state,
    output logic                 proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STRIPE = 2'b01,
        ST_STALL  = 2'b10
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_selector;
    logic                 w_selector_nxt;
    logic [WIDTH-1:0]     r_data0;
    logic [WIDTH-1:0]     r_data1;
    logic                 r_valid0;
    logic                 r_valid1;
    logic [CNT_WIDTH-1:0] r_words0;
    logic [CNT_WIDTH-1:0] r_words1;
    logic                 r_proto_err;
    logic                 w_proto_err_nxt;
    logic                 w_target_full;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_write0;
    logic                 w_write1;

    // Only the lane the selector points at can stall the upstream.
    assign w_target_full = r_selector ? almost_full_1 : almost_full_0;
    assign w_ready       = reset_L && !w_target_full;
    assign w_accept      = valid_in && w_ready;

    // Next-state / lane-write decode.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        w_state_nxt     = r_state;
        w_selector_nxt  = r_selector;
        w_proto_err_nxt = r_proto_err;
        w_write0        = 1'b0;
        w_write1        = 1'b0;

        if (w_accept) begin
            // Acceptance looks the same from every state: write the selected
            // lane, flip the selector, continue striping. In IDLE the
            // selector is already 0, so a new burst lands on lane 0.
            w_write0       = !r_selector;
            w_write1       = r_selector;
            w_selector_nxt = !r_selector;
            w_state_nxt    = ST_STRIPE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_selector_nxt = 1'b0;
                    if (valid_in) w_state_nxt = ST_STALL;
                end
                ST_STRIPE: begin
                    if (valid_in) begin
                        w_state_nxt = ST_STALL;
                    end else begin
                        // End of burst: an odd-length burst must not leave
                        // the next one starting on lane 1.
                        w_state_nxt    = ST_IDLE;
                        w_selector_nxt = 1'b0;
                    end
                end
                ST_STALL: begin
                    if (!valid_in) begin
                        // Upstream withdrew a word it was required to hold.
                        w_proto_err_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                        w_selector_nxt  = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_selector_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_2f) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_L) begin
            r_state     <= ST_IDLE;
            r_selector  <= 1'b0;
            r_data0     <= '0;
            r_data1     <= '0;
            r_valid0    <= 1'b0;
            r_valid1    <= 1'b0;
            r_words0    <= '0;
            r_words1    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_selector  <= w_selector_nxt;
            r_proto_err <= w_proto_err_nxt;
            r_valid0    <= w_write0;
            r_valid1    <= w_write1;
            if (w_write0) begin
                r_data0  <= data_in;
                r_words0 <= r_words0 + CNT_WIDTH'(1);
            end
            if (w_write1) begin
                r_data1  <= data_in;
                r_words1 <= r_words1 + CNT_WIDTH'(1);
            end
        end
    end

    assign ready_out   = w_ready;
    assign selector    = r_selector;
    assign data_out0   = r_data0;
    assign data_out1   = r_data1;
    assign valid_out_0 = r_valid0;
    assign valid_out_1 = r_valid1;
    assign words_0     = r_words0;
    assign words_1     = r_words1;
    assign state       = r_state;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_stripe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stripe_ctrl
//   Directed bench for stripe_ctrl. Stimulus pushes the expected (lane, word)
//   of every word it expects to be accepted into a queue; an independent
//   monitor pops and compares whenever a valid_out pulse appears. Status
//   outputs (state, selector, counters, ready_out, proto_err) are checked
//   inline against hand-computed values.
// -----------------------------------------------------------------------------
module tb_stripe_ctrl;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 8;

    logic                 clk_2f = 1'b0;
    logic                 reset_L;
    logic [WIDTH-1:0]     data_in;
    logic                 valid_in;
    logic                 ready_out;
    logic                 almost_full_0;
    logic                 almost_full_1;
    logic                 selector;
    logic [WIDTH-1:0]     data_out0;
    logic [WIDTH-1:0]     data_out1;
    logic                 valid_out_0;
    logic                 valid_out_1;
    logic [CNT_WIDTH-1:0] words_0;
    logic [CNT_WIDTH-1:0] words_1;
    logic [1:0]           state;
    logic                 proto_err;

    typedef struct packed {
        logic             lane;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    stripe_ctrl #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_2f        (clk_2f),
        .reset_L       (reset_L),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .almost_full_0 (almost_full_0),
        .almost_full_1 (almost_full_1),
        .selector      (selector),
        .data_out0     (data_out0),
        .data_out1     (data_out1),
        .valid_out_0   (valid_out_0),
        .valid_out_1   (valid_out_1),
        .words_0       (words_0),
        .words_1       (words_1),
        .state         (state),
        .proto_err     (proto_err)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock step; returns 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic lane);
        exp_t e;
        e.lane     = lane;
        e.data     = d;
        data_in    = d;
        valid_in   = 1'b1;
        exp_q.push_back(e);
        cyc();
    endtask

    task automatic idle();
        valid_in = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        cyc();
        reset_L  = 1'b1;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk_2f) begin
        if (valid_out_0 && valid_out_1) begin
            checks++;
            failures++;
            $display("FAIL both_valid: got valid_out_0=1 valid_out_1=1 expected at most one at %0t", $time);
        end else if (valid_out_0 || valid_out_1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got lane %0d data 0x%0h expected no output at %0t",
                         valid_out_1, valid_out_1 ? data_out1 : data_out0, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_lane", 64'(valid_out_1), 64'(e.lane));
                check("mon_data", 64'(valid_out_1 ? data_out1 : data_out0), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_L       = 1'b0;
        valid_in      = 1'b0;
        data_in       = '0;
        almost_full_0 = 1'b0;
        almost_full_1 = 1'b0;

        // Reset state.
        cyc();
        cyc();
        check("rst_selector",  64'(selector),    64'd0);
        check("rst_data0",     64'(data_out0),   64'd0);
        check("rst_data1",     64'(data_out1),   64'd0);
        check("rst_valid0",    64'(valid_out_0), 64'd0);
        check("rst_valid1",    64'(valid_out_1), 64'd0);
        check("rst_words0",    64'(words_0),     64'd0);
        check("rst_words1",    64'(words_1),     64'd0);
        check("rst_state",     64'(state),       64'd0);
        check("rst_proto_err", 64'(proto_err),   64'd0);
        check("rst_ready",     64'(ready_out),   64'd0);
        reset_L = 1'b1;
        #1;
        check("ready_after_rst", 64'(ready_out), 64'd1);

        // Four-word burst, alternating lanes starting at lane 0.
        send(32'hEEEEEEEE, 1'b0);
        check("b1_state_stripe", 64'(state), 64'd1);
        check("b1_selector", 64'(selector), 64'd1);
        send(32'hEEEEEEEF, 1'b1);
        send(32'hEEEEEEF0, 1'b0);
        send(32'hEEEEEEF1, 1'b1);
        idle();
        check("b1_words0",   64'(words_0),   64'd2);
        check("b1_words1",   64'(words_1),   64'd2);
        check("b1_data0",    64'(data_out0), 64'hEEEEEEF0);
        check("b1_data1",    64'(data_out1), 64'hEEEEEEF1);
        check("b1_state",    64'(state),     64'd0);
        check("b1_selector_idle", 64'(selector), 64'd0);

        // Odd burst, two idle cycles, then a new burst restarting on lane 0.
        do_reset();
        send(32'h1000_0001, 1'b0);
        send(32'h1000_0002, 1'b1);
        send(32'h1000_0003, 1'b0);
        idle();
        check("b2_state_idle", 64'(state),    64'd0);
        check("b2_selector",   64'(selector), 64'd0);
        idle();
        send(32'h2000_0001, 1'b0);
        send(32'h2000_0002, 1'b1);
        idle();
        check("b2_words0", 64'(words_0), 64'd3);
        check("b2_words1", 64'(words_1), 64'd2);

        // Stall on lane 1 for three cycles, then release.
        do_reset();
        send(32'h3000_000A, 1'b0);
        data_in       = 32'h3000_000B;
        valid_in      = 1'b1;
        almost_full_1 = 1'b1;
        #1;
        check("st_ready_low", 64'(ready_out), 64'd0);
        cyc();
        check("st_state1", 64'(state), 64'd2);
        check("st_sel_held", 64'(selector), 64'd1);
        cyc();
        check("st_state2", 64'(state), 64'd2);
        cyc();
        check("st_state3", 64'(state), 64'd2);
        check("st_words1_held", 64'(words_1), 64'd0);
        almost_full_1 = 1'b0;
        begin
            exp_t e;
            e.lane = 1'b1;
            e.data = 32'h3000_000B;
            exp_q.push_back(e);
        end
        #1;
        check("st_ready_release", 64'(ready_out), 64'd1);
        cyc();
        check("st_state_stripe", 64'(state),    64'd1);
        check("st_selector",     64'(selector), 64'd0);
        idle();
        check("st_words0", 64'(words_0), 64'd1);
        check("st_words1", 64'(words_1), 64'd1);

        // Reset in the middle of a four-word burst.
        do_reset();
        send(32'h4000_0001, 1'b0);
        send(32'h4000_0002, 1'b1);
        reset_L  = 1'b0;
        data_in  = 32'h4000_0003;
        valid_in = 1'b1;
        cyc();
        check("mr_data0",  64'(data_out0),   64'd0);
        check("mr_data1",  64'(data_out1),   64'd0);
        check("mr_valid0", 64'(valid_out_0), 64'd0);
        check("mr_valid1", 64'(valid_out_1), 64'd0);
        check("mr_words1", 64'(words_1),     64'd0);
        check("mr_sel",    64'(selector),    64'd0);
        check("mr_state",  64'(state),       64'd0);
        reset_L = 1'b1;
        send(32'h4000_0004, 1'b0);
        idle();
        check("mr_words0_after", 64'(words_0), 64'd1);
        check("mr_words1_after", 64'(words_1), 64'd0);

        // 512 back-to-back words: each counter wraps exactly once.
        do_reset();
        for (int i = 0; i < 512; i++) begin
            send(32'hA500_0000 + 32'(i), 1'(i % 2));
            if (i == 255) begin
                check("wrap_mid_words0", 64'(words_0), 64'd128);
                check("wrap_mid_words1", 64'(words_1), 64'd128);
            end
        end
        idle();
        check("wrap_words0", 64'(words_0), 64'd0);
        check("wrap_words1", 64'(words_1), 64'd0);

        // Protocol violation: valid_in withdrawn while stalled.
        do_reset();
        almost_full_0 = 1'b1;
        data_in       = 32'h5000_0001;
        valid_in      = 1'b1;
        cyc();
        check("pe_state_stall", 64'(state),     64'd2);
        check("pe_before",      64'(proto_err), 64'd0);
        idle();
        check("pe_set",        64'(proto_err), 64'd1);
        check("pe_state_idle", 64'(state),     64'd0);
        check("pe_sel",        64'(selector),  64'd0);
        almost_full_0 = 1'b0;
        send(32'h5000_0002, 1'b0);
        idle();
        idle();
        check("pe_sticky", 64'(proto_err), 64'd1);
        do_reset();
        #1;
        check("pe_cleared", 64'(proto_err), 64'd0);

        cyc();
        cyc();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
